// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared FSM state type and bus-width limit for the gate test sequencer
package gate_test_pkg;
  localparam int N_MAX = 4;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// settle_timer: loadable 4-bit down-counter with zero flag; holds at zero
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] val,
  output logic       zero
);
  logic [3:0] cnt;
  assign zero = cnt == 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= 4'd0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 4'd1;
endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: applies every N-bit vector to an inverter, checks ~v, reports error count and pass
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   settle_cycles,
  output logic [N-1:0] dut_in,
  input  logic [N-1:0] dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [4:0]   err_count
);
  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("gate_test_sequencer: N out of range");
  end
  state_t state, state_nxt;
  logic [3:0] s_lat;
  logic [N-1:0] v;
  logic t_zero, mism, last;
  assign mism = dut_out != ~v;
  assign last = &v;
  assign dut_in = v;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // counter preloaded with S-1 so its zero flag marks the final SETTLE cycle
  settle_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == APPLY),
    .dec  (state == SETTLE),
    .val  (s_lat - 4'd1),
    .zero (t_zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? APPLY : IDLE;
      APPLY:   state_nxt = (s_lat == 4'd0) ? CHECK : SETTLE;
      SETTLE:  state_nxt = t_zero ? CHECK : SETTLE;
      CHECK:   state_nxt = last ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_lat     <= 4'd0;
      v         <= '0;
      err_count <= 5'd0;
      pass      <= 1'b0;
    end else if (state == IDLE && start) begin
      s_lat     <= settle_cycles;
      v         <= '0;
      err_count <= 5'd0;
      pass      <= 1'b0;
    end else if (state == CHECK) begin
      if (mism) err_count <= err_count + 5'd1;
      if (last) pass <= (err_count == 5'd0) && !mism;
      else v <= v + N'(1);
    end
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: randomized self-checking bench for N=2 and N=1 sequencers with faulty inverter models
module tb_gate_test_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic start2 = 1'b0, start1 = 1'b0;
  logic [3:0] settle2 = 4'd0, settle1 = 4'd0;
  logic [1:0] dut_in2, dut_out2, keep2 = 2'b11;
  logic [0:0] dut_in1, dut_out1;
  logic busy2, done2, pass2, busy1, done1, pass1;
  logic [4:0] err_count2, err_count1;
  logic [1:0] flip2 [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
  logic [2:0] p1;
  logic delay1 = 1'b1;
  int checks = 0, failures = 0;
  int cyc, dones, seq_n, seq_code;
  logic [1:0] seq_last;
  always #5 clk = ~clk;
  assign dut_out2 = (~dut_in2 ^ flip2[dut_in2]) & keep2;
  always @(posedge clk) p1 <= rst ? 3'b111 : {p1[1:0], ~dut_in1};
  assign dut_out1 = delay1 ? p1[2] : ~dut_in1;
  gate_test_sequencer #(.N(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .settle_cycles(settle2), .dut_in(dut_in2),
    .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2)
  );
  gate_test_sequencer #(.N(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .settle_cycles(settle1), .dut_in(dut_in1),
    .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1)
  );
  function automatic logic [4:0] exp_err2();
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] inv = ~2'(i);
      if (((inv ^ flip2[i]) & keep2) != inv) n++;
    end
    return 5'(n);
  endfunction
  task automatic run2(input int s, input bit wiggle);
    int t = 4 * (s + 2);
    cyc = -1; dones = 0; seq_n = 0; seq_code = 0; seq_last = 2'd0;
    @(negedge clk); settle2 = 4'(s); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy2 && (seq_n == 0 || seq_last != dut_in2)) begin
        seq_n++; seq_code = seq_code * 4 + int'(dut_in2); seq_last = dut_in2;
      end
      if (done2) begin dones++; if (cyc < 0) cyc = c; end
      if (cyc >= 0 && c > cyc + 2) break;
      if (wiggle && c < t - 2) begin start2 = 1'($urandom); settle2 = 4'($urandom); end
      else if (wiggle) start2 = 1'b0;
    end
  endtask
  task automatic check_run2(input string name, input int s);
    logic [4:0] e = exp_err2();
    checks += 5;
    if (cyc !== 4 * (s + 2)) begin failures++; $display("FAIL %s cycles got=%0d exp=%0d", name, cyc, 4 * (s + 2)); end
    if (dones !== 1) begin failures++; $display("FAIL %s done_pulses got=%0d exp=1", name, dones); end
    if (err_count2 !== e) begin failures++; $display("FAIL %s err_count got=%0d exp=%0d", name, err_count2, e); end
    if (pass2 !== (e == 5'd0)) begin failures++; $display("FAIL %s pass got=%b exp=%b", name, pass2, e == 5'd0); end
    if (seq_n !== 4 || seq_code !== 27) begin failures++; $display("FAIL %s dut_in_seq n=%0d code=%0d exp n=4 code=27", name, seq_n, seq_code); end
  endtask
  task automatic run1(input int s);
    cyc = -1; dones = 0;
    @(negedge clk); settle1 = 4'(s); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done1) begin dones++; if (cyc < 0) cyc = c; end
      if (cyc >= 0 && c > cyc + 2) break;
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks += 2;
    if ({dut_in2, busy2, done2, pass2, err_count2} !== 11'd0) begin failures++; $display("FAIL reset_n2 got=%h exp=0", {dut_in2, busy2, done2, pass2, err_count2}); end
    if ({dut_in1, busy1, done1, pass1, err_count1} !== 9'd0) begin failures++; $display("FAIL reset_n1 got=%h exp=0", {dut_in1, busy1, done1, pass1, err_count1}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy2, done2, busy1, done1} !== 4'd0) begin failures++; $display("FAIL reset_idle got=%b exp=0000", {busy2, done2, busy1, done1}); end
  endtask
  task automatic test_ideal;
    keep2 = 2'b11;
    for (int i = 0; i < 4; i++) flip2[i] = 2'd0;
    run2(0, 1'b0);
    check_run2("ideal_s0", 0);
  endtask
  task automatic test_stuck;
    keep2 = 2'b10;
    run2(0, 1'b0);
    checks++;
    if (err_count2 !== 5'd2) begin failures++; $display("FAIL stuck_bit0 err_count got=%0d exp=2", err_count2); end
    check_run2("stuck_bit0", 0);
    keep2 = 2'b11;
  endtask
  task automatic test_delay;
    run1(1);
    checks += 2;
    if (pass1 !== 1'b0) begin failures++; $display("FAIL delay_s1 pass got=%b exp=0", pass1); end
    if (err_count1 !== 5'd1) begin failures++; $display("FAIL delay_s1 err_count got=%0d exp=1", err_count1); end
    run1(3);
    checks += 3;
    if (pass1 !== 1'b1) begin failures++; $display("FAIL delay_s3 pass got=%b exp=1", pass1); end
    if (cyc !== 10) begin failures++; $display("FAIL delay_s3 cycles got=%0d exp=10", cyc); end
    if (dones !== 1) begin failures++; $display("FAIL delay_s3 done_pulses got=%0d exp=1", dones); end
  endtask
  task automatic test_reset_mid_run;
    int extra_done = 0, extra_busy = 0;
    @(negedge clk); settle2 = 4'd2; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_in2 !== 2'd2 || busy2 !== 1'b1) begin failures++; $display("FAIL midrun_pre dut_in=%0d busy=%b exp 2,1", dut_in2, busy2); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dut_in2, busy2, done2, pass2, err_count2} !== 11'd0) begin failures++; $display("FAIL midrun_async got=%h exp=0", {dut_in2, busy2, done2, pass2, err_count2}); end
    @(negedge clk); rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done2) extra_done++;
      if (busy2) extra_busy++;
    end
    checks++;
    if (extra_done !== 0 || extra_busy !== 0) begin failures++; $display("FAIL midrun_no_done done=%0d busy=%0d exp 0,0", extra_done, extra_busy); end
    run2(1, 1'b0);
    check_run2("after_reset", 1);
  endtask
  task automatic test_busy_start;
    int s = $urandom_range(1, 5);
    run2(s, 1'b1);
    check_run2("busy_start", s);
  endtask
  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      int s = $urandom_range(0, 9);
      keep2 = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      for (int i = 0; i < 4; i++) flip2[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      run2(s, 1'b0);
      check_run2("random", s);
    end
    keep2 = 2'b11;
    for (int i = 0; i < 4; i++) flip2[i] = 2'd0;
  endtask
  task automatic test_back_to_back;
    bit seen = 0;
    keep2 = 2'b10;
    @(negedge clk); settle2 = 4'd0; start2 = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = done2;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL b2b_first_done got=0 exp=1"); end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0) begin failures++; $display("FAIL b2b_idle busy got=%b exp=0", busy2); end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b1 || dut_in2 !== 2'd0 || err_count2 !== 5'd0) begin failures++; $display("FAIL b2b_restart busy=%b dut_in=%0d err=%0d exp 1,0,0", busy2, dut_in2, err_count2); end
    start2 = 1'b0; keep2 = 2'b11; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = done2;
    end
    checks++;
    if (!seen || pass2 !== 1'b1 || err_count2 !== 5'd0) begin failures++; $display("FAIL b2b_second done=%b pass=%b err=%0d exp 1,1,0", seen, pass2, err_count2); end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    test_reset;
    test_ideal;
    test_stuck;
    test_delay;
    test_reset_mid_run;
    test_busy_start;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
